// File: rtl/instruction_encoder_if.sv
// Request/response bundle for the instruction encoder: request fields in, encoded words and counters out.
// The encoder takes the slave side; the producer/consumer side takes the master side.
interface instruction_encoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       op_sel;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [31:0]      imm;
    logic [11:0]      csr_addr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_word;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;
    logic [7:0]       err_count;

    modport master (
        output in_valid, op_sel, rd, rs1, rs2, imm, csr_addr, out_ready,
        input  in_ready, out_valid, out_word, out_err, enc_count, err_count
    );

    modport slave (
        input  in_valid, op_sel, rd, rs1, rs2, imm, csr_addr, out_ready,
        output in_ready, out_valid, out_word, out_err, enc_count, err_count
    );
endinterface

// File: rtl/instruction_encoder.sv
// Packs op select + fields into an RV32I/Zicsr/privileged word with range checks; one-cycle latency.
// 2-entry output buffer: in_ready drops only while both entries are occupied.
module instruction_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    instruction_encoder_if.slave  bus
);

    typedef enum logic [3:0] {
        F_BAD, F_B, F_I, F_SH, F_R, F_S, F_CSR, F_U, F_J, F_SYS
    } fmt_t;

    typedef struct packed {
        logic        err;
        logic [31:0] word;
    } entry_t;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [1:0] FULL       = 2'(DEPTH);

    fmt_t               fmt;
    logic [2:0]         f3;
    logic               alt;
    logic [6:0]         opc;
    logic [31:0]        sys_word;
    logic [31:0]        enc;
    logic               ok;
    entry_t             new_entry;

    logic signed [31:0] simm;
    logic               imm12_ok;
    logic               shamt_ok;
    logic               br_ok;
    logic               jal_ok;
    logic               upper_ok;

    logic [1:0]         count;
    entry_t             slot0;
    entry_t             slot1;
    logic [CNT_W-1:0]   enc_cnt;
    logic [7:0]         err_cnt;
    logic               push;
    logic               pop;

    assign simm     = bus.imm;
    assign imm12_ok = (simm >= -2048) && (simm <= 2047);
    assign shamt_ok = (simm >= 0) && (simm <= 31);
    assign br_ok    = (simm >= -4096) && (simm <= 4094) && !bus.imm[0];
    assign jal_ok   = (simm >= -1048576) && (simm <= 1048574) && !bus.imm[0];
    assign upper_ok = (bus.imm[11:0] == 12'd0);

    always_comb begin
        fmt      = F_BAD;
        f3       = 3'b000;
        alt      = 1'b0;
        opc      = 7'b0000000;
        sys_word = 32'h0000_0000;
        case (bus.op_sel)
            6'd0:  begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'b000; end
            6'd1:  begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'b001; end
            6'd2:  begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'b100; end
            6'd3:  begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'b101; end
            6'd4:  begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'b110; end
            6'd5:  begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'b111; end
            6'd6:  begin fmt = F_I;  opc = OPC_OPIMM;  f3 = 3'b000; end
            6'd7:  begin fmt = F_I;  opc = OPC_OPIMM;  f3 = 3'b010; end
            6'd8:  begin fmt = F_I;  opc = OPC_OPIMM;  f3 = 3'b011; end
            6'd9:  begin fmt = F_I;  opc = OPC_OPIMM;  f3 = 3'b100; end
            6'd10: begin fmt = F_I;  opc = OPC_OPIMM;  f3 = 3'b110; end
            6'd11: begin fmt = F_I;  opc = OPC_OPIMM;  f3 = 3'b111; end
            6'd12: begin fmt = F_SH; opc = OPC_OPIMM;  f3 = 3'b001; end
            6'd13: begin fmt = F_SH; opc = OPC_OPIMM;  f3 = 3'b101; end
            6'd14: begin fmt = F_SH; opc = OPC_OPIMM;  f3 = 3'b101; alt = 1'b1; end
            6'd15: begin fmt = F_R;  opc = OPC_OP;     f3 = 3'b000; end
            6'd16: begin fmt = F_R;  opc = OPC_OP;     f3 = 3'b000; alt = 1'b1; end
            6'd17: begin fmt = F_R;  opc = OPC_OP;     f3 = 3'b001; end
            6'd18: begin fmt = F_R;  opc = OPC_OP;     f3 = 3'b010; end
            6'd19: begin fmt = F_R;  opc = OPC_OP;     f3 = 3'b011; end
            6'd20: begin fmt = F_R;  opc = OPC_OP;     f3 = 3'b100; end
            6'd21: begin fmt = F_R;  opc = OPC_OP;     f3 = 3'b101; end
            6'd22: begin fmt = F_R;  opc = OPC_OP;     f3 = 3'b101; alt = 1'b1; end
            6'd23: begin fmt = F_R;  opc = OPC_OP;     f3 = 3'b110; end
            6'd24: begin fmt = F_R;  opc = OPC_OP;     f3 = 3'b111; end
            6'd25: begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'b000; end
            6'd26: begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'b001; end
            6'd27: begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'b010; end
            6'd28: begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'b100; end
            6'd29: begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'b101; end
            6'd30: begin fmt = F_S;  opc = OPC_STORE;  f3 = 3'b000; end
            6'd31: begin fmt = F_S;  opc = OPC_STORE;  f3 = 3'b001; end
            6'd32: begin fmt = F_S;  opc = OPC_STORE;  f3 = 3'b010; end
            6'd33: begin fmt = F_CSR; opc = OPC_SYSTEM; f3 = 3'b001; end
            6'd34: begin fmt = F_CSR; opc = OPC_SYSTEM; f3 = 3'b010; end
            6'd35: begin fmt = F_CSR; opc = OPC_SYSTEM; f3 = 3'b011; end
            6'd36: begin fmt = F_CSR; opc = OPC_SYSTEM; f3 = 3'b101; end
            6'd37: begin fmt = F_CSR; opc = OPC_SYSTEM; f3 = 3'b110; end
            6'd38: begin fmt = F_CSR; opc = OPC_SYSTEM; f3 = 3'b111; end
            6'd39: begin fmt = F_U;  opc = OPC_LUI;    end
            6'd40: begin fmt = F_U;  opc = OPC_AUIPC;  end
            6'd41: begin fmt = F_J;  opc = OPC_JAL;    end
            6'd42: begin fmt = F_I;  opc = OPC_JALR;   f3 = 3'b000; end
            6'd43: begin fmt = F_SYS; sys_word = 32'h0000_0073; end
            6'd44: begin fmt = F_SYS; sys_word = 32'h0010_0073; end
            6'd45: begin fmt = F_SYS; sys_word = 32'h3020_0073; end
            6'd46: begin fmt = F_SYS; sys_word = 32'h1020_0073; end
            6'd47: begin fmt = F_SYS; sys_word = 32'h1050_0073; end
            default: fmt = F_BAD;
        endcase
    end

    // CSR register and immediate forms share a layout: the rs1 slot carries zimm for the *i variants.
    always_comb begin
        ok  = 1'b0;
        enc = 32'h0000_0000;
        case (fmt)
            F_B: begin
                ok  = br_ok;
                enc = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, f3,
                       bus.imm[4:1], bus.imm[11], opc};
            end
            F_I: begin
                ok  = imm12_ok;
                enc = {bus.imm[11:0], bus.rs1, f3, bus.rd, opc};
            end
            F_SH: begin
                ok  = shamt_ok;
                enc = {1'b0, alt, 5'b00000, bus.imm[4:0], bus.rs1, f3, bus.rd, opc};
            end
            F_R: begin
                ok  = 1'b1;
                enc = {1'b0, alt, 5'b00000, bus.rs2, bus.rs1, f3, bus.rd, opc};
            end
            F_S: begin
                ok  = imm12_ok;
                enc = {bus.imm[11:5], bus.rs2, bus.rs1, f3, bus.imm[4:0], opc};
            end
            F_CSR: begin
                ok  = 1'b1;
                enc = {bus.csr_addr, bus.rs1, f3, bus.rd, opc};
            end
            F_U: begin
                ok  = upper_ok;
                enc = {bus.imm[31:12], bus.rd, opc};
            end
            F_J: begin
                ok  = jal_ok;
                enc = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, opc};
            end
            F_SYS: begin
                ok  = 1'b1;
                enc = sys_word;
            end
            default: begin
                ok  = 1'b0;
                enc = 32'h0000_0000;
            end
        endcase
        new_entry.err  = !ok;
        new_entry.word = ok ? enc : 32'h0000_0000;
    end

    assign bus.in_ready  = (count < FULL);
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_word  = slot0.word;
    assign bus.out_err   = slot0.err;
    assign bus.enc_count = enc_cnt;
    assign bus.err_count = err_cnt;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // slot0 is always the head; a pop shifts slot1 forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 2'd0;
            slot0   <= '0;
            slot1   <= '0;
            enc_cnt <= '0;
            err_cnt <= 8'd0;
        end else begin
            if (push) begin
                enc_cnt <= enc_cnt + CNT_W'(1);
                if (new_entry.err && (err_cnt != 8'hFF)) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= new_entry;
                    end else begin
                        slot1 <= new_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    slot0 <= new_entry;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
